trig_wave_ctrl: RTL and testbench

Sequencer for the triangle/sawtooth wave generator in the DSP chain. It accepts a burst command over a valid/ready handshake and produces the generator's sample-rate enable (`clk_en`), run enable (`dc`) and duty select (`dc_sel`). It counts completed waveform periods using the generator's output fed back, and stops cleanly at the bottom of a period after N periods or on a stop request. It signals completion with a one-cycle `done` pulse.

---
 rtl/trig_wave_ctrl.sv | 126 ++++++++++++
 tb/tb_trig_wave_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_wave_ctrl.sv
// Burst sequencer for the triangle/sawtooth generator: handshake-accepted bursts, divided sample enable,
// period counting from wave feedback. Define TWC_SWEEP_EN to step dc_sel on every period end that continues in RUN.
module trig_wave_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DIV_W-1:0]        cmd_div,
  input  logic [1:0]              cmd_sel,
  input  logic [CNT_W-1:0]        cmd_periods,
  input  logic                    stop,
  input  logic signed [15:0]      wave_in,
  output logic                    clk_en,
  output logic                    dc,
  output logic [1:0]              dc_sel,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        period_cnt
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] periods_q;
  logic             peak_seen;

  logic             at_peak;
  logic             at_bottom;
  logic             period_end;
  logic [CNT_W-1:0] cnt_inc;
  logic             complete;

  assign cmd_ready = (state == IDLE);

  // peak_seen gates the bottom detect so a wave held at -32768 is counted only once
  always_comb begin
    at_peak    = (wave_in == 16'sh7FFF);
    at_bottom  = (wave_in == 16'sh8000);
    period_end = peak_seen && at_bottom;
    cnt_inc    = (period_cnt == '1) ? period_cnt : period_cnt + CNT_W'(1);
    complete   = period_end && (periods_q != '0) && (cnt_inc == periods_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      div_q      <= '0;
      div_cnt    <= '0;
      periods_q  <= '0;
      peak_seen  <= 1'b0;
      clk_en     <= 1'b1;
      dc         <= 1'b0;
      dc_sel     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      period_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          clk_en <= 1'b1;
          dc     <= 1'b0;
          busy   <= 1'b0;
          if (cmd_valid) begin
            div_q     <= cmd_div;
            dc_sel    <= cmd_sel;
            periods_q <= cmd_periods;
            clk_en    <= 1'b0;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          div_cnt    <= '0;
          period_cnt <= '0;
          peak_seen  <= 1'b0;
          clk_en     <= 1'b0;
          dc         <= 1'b1;
          state      <= RUN;
        end
        RUN, DRAIN: begin
          if (div_cnt == div_q) begin
            div_cnt <= '0;
            clk_en  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            clk_en  <= 1'b0;
          end
          if (at_peak)
            peak_seen <= 1'b1;
          if (period_end) begin
            peak_seen  <= 1'b0;
            period_cnt <= cnt_inc;
          end
          if (period_end && (state == DRAIN || complete || stop)) begin
            state  <= DONE;
            done   <= 1'b1;
            dc     <= 1'b0;
            clk_en <= 1'b1;
          end else if (state == RUN && stop) begin
            state <= DRAIN;
          end
`ifdef TWC_SWEEP_EN
          if (state == RUN && period_end && !complete && !stop)
            dc_sel <= dc_sel + 2'd1;
`else
          dc_sel <= dc_sel;
`endif
        end
        DONE: begin
          clk_en <= 1'b1;
          dc     <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_wave_ctrl.sv
// Directed bench for trig_wave_ctrl with a behavioural triangle generator (step 512) closing the feedback loop.
module tb_trig_wave_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [15:0]        cmd_div = '0;
  logic [1:0]         cmd_sel = '0;
  logic [15:0]        cmd_periods = '0;
  logic               stop = 1'b0;
  logic signed [15:0] wave_in;
  logic               clk_en;
  logic               dc;
  logic [1:0]         dc_sel;
  logic               busy;
  logic               done;
  logic [15:0]        period_cnt;

  int checks = 0;
  int failures = 0;

  trig_wave_ctrl #(.DIV_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_div(cmd_div), .cmd_sel(cmd_sel), .cmd_periods(cmd_periods), .stop(stop),
    .wave_in(wave_in), .clk_en(clk_en), .dc(dc), .dc_sel(dc_sel), .busy(busy),
    .done(done), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  // Generator: parks at -32768 when not running, otherwise ramps +/-512 per enable, clamping at the rails
  logic gdir;
  always @(posedge clk) begin
    if (!rst || (clk_en && !dc)) begin
      wave_in <= 16'sh8000;
      gdir    <= 1'b0;
    end else if (clk_en) begin
      if (!gdir) begin
        if (wave_in >= 16'sd32255) begin
          wave_in <= 16'sh7FFF;
          gdir    <= 1'b1;
        end else wave_in <= wave_in + 16'sd512;
      end else begin
        if (wave_in <= -16'sd32256) begin
          wave_in <= 16'sh8000;
          gdir    <= 1'b0;
        end else wave_in <= wave_in - 16'sd512;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic [15:0] d, input logic [1:0] s, input logic [15:0] p);
    cmd_div = d; cmd_sel = s; cmd_periods = p; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, busy, dc, clk_en, done} !== 5'b10010 || period_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: ready/busy/dc/clk_en/done=%b period_cnt=%0d required 10010 / 0",
               {cmd_ready, busy, dc, clk_en, done}, period_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_burst();
    int idx; int rets; int ret_idx; logic signed [15:0] prev;
    start_cmd(16'd0, 2'd2, 16'd2);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || dc_sel !== 2'd2 || clk_en !== 1'b0) begin
      failures++;
      $display("FAIL single_arm: ready=%b busy=%b dc_sel=%0d clk_en=%b required 0 1 2 0", cmd_ready, busy, dc_sel, clk_en);
    end
    tick();
    checks++;
    if (dc !== 1'b1) begin failures++; $display("FAIL single_dc: dc=%b required 1", dc); end
    idx = 0; rets = 0; ret_idx = -10; prev = wave_in;
    while (idx < 3000) begin
      tick(); idx++;
      if (idx == ret_idx + 1) begin
        checks++;
        if (period_cnt !== 16'(rets)) begin
          failures++; $display("FAIL single_period_cnt: period_cnt=%0d required %0d", period_cnt, rets);
        end
      end
      if (done === 1'b1) break;
      if (wave_in == 16'sh8000 && prev != 16'sh8000) begin rets++; ret_idx = idx; end
      prev = wave_in;
    end
    checks++;
    if (done !== 1'b1 || rets != 2 || idx != ret_idx + 1) begin
      failures++; $display("FAIL single_done: done=%b returns=%0d idx=%0d ret_idx=%0d required 1 2 ret_idx+1", done, rets, idx, ret_idx);
    end
    checks++;
    if (dc !== 1'b0 || clk_en !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL single_done_outs: dc=%b clk_en=%b ready=%b required 0 1 0", dc, clk_en, cmd_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || period_cnt !== 16'd2) begin
      failures++; $display("FAIL single_idle: done=%b ready=%b busy=%b period_cnt=%0d required 0 1 0 2", done, cmd_ready, busy, period_cnt);
    end
  endtask

  task automatic test_divider();
    int idx; logic expv;
    start_cmd(16'd3, 2'd1, 16'd1);
    tick();
    idx = 0;
    while (idx <= 12) begin
      expv = (idx != 0) && (idx % 4 == 0);
      checks++;
      if (clk_en !== expv) begin
        failures++; $display("FAIL divider_clk_en[%0d]: clk_en=%b required %b", idx, clk_en, expv);
      end
      tick(); idx++;
    end
    while (done !== 1'b1 && idx < 3000) begin tick(); idx++; end
    checks++;
    if (done !== 1'b1 || idx != 1026 || period_cnt !== 16'd1) begin
      failures++; $display("FAIL divider_span: done=%b idx=%0d period_cnt=%0d required 1 1026 1", done, idx, period_cnt);
    end
    tick();
  endtask

  task automatic test_graceful_stop();
    int idx; int rets; int ret_idx; logic signed [15:0] prev; logic stopped; logic dc_bad;
    start_cmd(16'd0, 2'd0, 16'd0);
    tick();
    idx = 0; rets = 0; ret_idx = -10; prev = wave_in; stopped = 1'b0; dc_bad = 1'b0;
    while (idx < 3000) begin
      tick(); idx++;
      stop = 1'b0;
      if (done === 1'b1) break;
      if (wave_in == 16'sh8000 && prev != 16'sh8000) begin rets++; ret_idx = idx; end
      prev = wave_in;
      if (dc !== 1'b1) dc_bad = 1'b1;
      if (rets == 2 && wave_in == 16'sd0 && !stopped) begin stop = 1'b1; stopped = 1'b1; end
    end
    checks++;
    if (done !== 1'b1 || rets != 3 || idx != ret_idx + 1 || period_cnt !== 16'd3) begin
      failures++; $display("FAIL stop_done: done=%b returns=%0d idx=%0d ret_idx=%0d period_cnt=%0d required 1 3 ret_idx+1 3",
                           done, rets, idx, ret_idx, period_cnt);
    end
    checks++;
    if (dc_bad !== 1'b0 || stopped !== 1'b1) begin
      failures++; $display("FAIL stop_dc_held: dc_dropped=%b stop_issued=%b required 0 1", dc_bad, stopped);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx; int accepts;
    cmd_div = 16'd0; cmd_sel = 2'd1; cmd_periods = 16'd1; cmd_valid = 1'b1;
    idx = 0; accepts = 0;
    while (done !== 1'b1 && idx < 3000) begin
      if (cmd_ready === 1'b1) accepts++;
      tick(); idx++;
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0 || accepts != 1) begin
      failures++; $display("FAIL b2b_single_accept: done=%b ready=%b accepts=%0d required 1 0 1", done, cmd_ready, accepts);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: ready=%b done=%b required 1 0", cmd_ready, done);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_second_accept: ready=%b busy=%b required 0 1", cmd_ready, busy);
    end
    idx = 0;
    while (done !== 1'b1 && idx < 3000) begin tick(); idx++; end
    checks++;
    if (done !== 1'b1 || period_cnt !== 16'd1) begin
      failures++; $display("FAIL b2b_second_done: done=%b period_cnt=%0d required 1 1", done, period_cnt);
    end
    tick();
  endtask

  task automatic test_abort();
    logic bad;
    start_cmd(16'd0, 2'd0, 16'd0);
    repeat (300) tick();
    checks++;
    if (dc !== 1'b1 || period_cnt !== 16'd1) begin
      failures++; $display("FAIL abort_pre: dc=%b period_cnt=%0d required 1 1", dc, period_cnt);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (dc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || period_cnt !== 16'd0) begin
      failures++; $display("FAIL abort_reset: dc=%b busy=%b done=%b ready=%b period_cnt=%0d required 0 0 0 1 0",
                           dc, busy, done, cmd_ready, period_cnt);
    end
    bad = 1'b0;
    repeat (700) begin
      tick();
      if (done !== 1'b0 || dc !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL abort_quiet: done_or_dc_seen=%b required 0", bad); end
  endtask

  task automatic test_sweep();
    int idx; int rets; int ret_idx; logic signed [15:0] prev; logic [1:0] exp_sel [0:3];
`ifdef TWC_SWEEP_EN
    exp_sel[0] = 2'd3; exp_sel[1] = 2'd0; exp_sel[2] = 2'd1; exp_sel[3] = 2'd1;
`else
    exp_sel[0] = 2'd3; exp_sel[1] = 2'd3; exp_sel[2] = 2'd3; exp_sel[3] = 2'd3;
`endif
    start_cmd(16'd0, 2'd3, 16'd3);
    checks++;
    if (dc_sel !== exp_sel[0]) begin failures++; $display("FAIL sweep_start: dc_sel=%0d required %0d", dc_sel, exp_sel[0]); end
    tick();
    idx = 0; rets = 0; ret_idx = -10; prev = wave_in;
    while (idx < 3000) begin
      tick(); idx++;
      if (idx == ret_idx + 1 && rets < 3) begin
        checks++;
        if (dc_sel !== exp_sel[rets] || period_cnt !== 16'(rets)) begin
          failures++; $display("FAIL sweep_period%0d: dc_sel=%0d period_cnt=%0d required %0d %0d",
                               rets, dc_sel, period_cnt, exp_sel[rets], rets);
        end
      end
      if (done === 1'b1) break;
      if (wave_in == 16'sh8000 && prev != 16'sh8000) begin rets++; ret_idx = idx; end
      prev = wave_in;
    end
    checks++;
    if (done !== 1'b1 || rets != 3 || period_cnt !== 16'd3 || dc_sel !== exp_sel[3]) begin
      failures++; $display("FAIL sweep_done: done=%b returns=%0d period_cnt=%0d dc_sel=%0d required 1 3 3 %0d",
                           done, rets, period_cnt, dc_sel, exp_sel[3]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_divider();
    test_graceful_stop();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
